// File: rtl/seq_mult8_pkg.sv
// Shared definitions for the seq_mult8 shift-and-add multiplier.
// The optional zero-operand shortcut is selected by SEQ_MULT8_ZERO_BYPASS_EN.
package seq_mult8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 16;
  localparam int ITERATIONS = 8;
  localparam logic [3:0] LAST_COUNT = 4'(ITERATIONS - 1);

  // Either operand being zero makes the product zero without iterating.
  function automatic logic zero_operand(input logic [OPERAND_W-1:0] x,
                                        input logic [OPERAND_W-1:0] y);
    return (x == '0) || (y == '0);
  endfunction

endpackage

// File: rtl/seq_mult8_adder8bit.sv
// 8-bit ripple-carry adder (adder8bit) used as the accumulate stage of seq_mult8.
module adder8bit (
  input  logic [7:0] X,
  input  logic [7:0] Y,
  input  logic       C0,
  output logic [7:0] sum,
  output logic       C8
);

  logic carry;

  // The carry ripples bit by bit through a chain of full adders.
  always_comb begin
    carry = C0;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = X[i] ^ Y[i] ^ carry;
      carry  = (X[i] & Y[i]) | (carry & (X[i] ^ Y[i]));
    end
    C8 = carry;
  end

endmodule

// File: rtl/seq_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier, 8 iterations per product.
// Define SEQ_MULT8_ZERO_BYPASS_EN to finish zero-operand requests immediately.
module seq_mult8
  import seq_mult8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  state_t      state;
  state_t      next_state;
  logic [7:0]  acc;
  logic [7:0]  mplr;
  logic [7:0]  mcand;
  logic [3:0]  count;
  logic        accept;
  logic        last_step;
`ifdef SEQ_MULT8_ZERO_BYPASS_EN
  logic        bypass;
`endif

  logic [7:0]  add_y;
  logic [7:0]  add_sum;
  logic        add_c8;
  logic [15:0] shifted;

  assign add_y   = mplr[0] ? mcand : 8'h00;
  // Keeping the carry as the new MSB means no partial product bit is ever lost.
  assign shifted = {add_c8, add_sum, mplr[7:1]};

  adder8bit u_adder (
    .X   (acc),
    .Y   (add_y),
    .C0  (1'b0),
    .sum (add_sum),
    .C8  (add_c8)
  );

  assign last_step = (count == LAST_COUNT);
  assign busy      = (state == BUSY);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
`ifdef SEQ_MULT8_ZERO_BYPASS_EN
    bypass     = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = BUSY;
`ifdef SEQ_MULT8_ZERO_BYPASS_EN
          if (zero_operand(a, b)) begin
            bypass     = 1'b1;
            next_state = DONE;
          end
`endif
        end else if (state == DONE) begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Start is ignored while BUSY, so a capture can only happen in IDLE or DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mplr    <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      acc   <= '0;
      mplr  <= b;
      count <= '0;
`ifdef SEQ_MULT8_ZERO_BYPASS_EN
      if (bypass) begin
        product <= '0;
      end
`endif
    end else if (state == BUSY) begin
      {acc, mplr} <= shifted;
      count       <= count + 4'd1;
      if (last_step) begin
        product <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult8.sv
// Self-checking bench for seq_mult8: directed cases plus random operands
// compared against plain a*b and the documented cycle timing.
module tb_seq_mult8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_prod;

  seq_mult8 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bypass_expected(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MULT8_ZERO_BYPASS_EN
    return (x == 8'd0) || (y == 8'd0);
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction: request at the next edge (E0), then verify every
  // following cycle against the expected latency and the plain product.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit scramble);
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (bypass_expected(x, y)) begin
      check("bypass_done", done, 1);
      check("bypass_busy", busy, 0);
      check("bypass_prod", product, 0);
      model_prod = 16'd0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        check("busy_high", busy, 1);
        check("done_low", done, 0);
        check("prod_hold", product, model_prod);
        if (scramble) begin
          a = 8'($urandom);
          b = 8'($urandom);
        end
        @(negedge clk);
      end
      model_prod = 16'(x) * 16'(y);
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 0);
      check("product", product, model_prod);
    end
    @(negedge clk);
    check("done_drop", done, 0);
    check("busy_idle", busy, 0);
    check("prod_after", product, model_prod);
  endtask

  initial begin
    model_prod = 16'd0;
    rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd9;

    // Reset with a coincident start request.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    do_op(8'd13, 8'd11, 1'b0);
    do_op(8'd255, 8'd255, 1'b1);
    do_op(8'd128, 8'd2, 1'b0);
    do_op(8'd0, 8'd77, 1'b0);
    do_op(8'd77, 8'd0, 1'b1);

    // Second start arriving at E3 must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd6;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("ign_busy", busy, 1);
      check("ign_done", done, 0);
      if (k == 2) begin
        start = 1'b1; a = 8'd9; b = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    model_prod = 16'd30;
    check("ign_done_pulse", done, 1);
    check("ign_product", product, model_prod);
    @(negedge clk);
    check("ign_idle", done, 0);

    // Reset during BUSY aborts the operation and clears the product.
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    model_prod = 16'd0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_prod", product, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_prod_hold", product, 0);
    end
    do_op(8'd7, 8'd7, 1'b0);

    // Continuous start: back-to-back operations every 9 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd4;
    @(negedge clk);
    for (int op = 0; op < 3; op++) begin
      for (int k = 0; k < 8; k++) begin
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        @(negedge clk);
      end
      model_prod = 16'd12;
      check("b2b_done_pulse", done, 1);
      check("b2b_product", product, model_prod);
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_restart_busy", busy, 1);
    repeat (8) @(negedge clk);
    check("b2b_final_done", done, 1);
    @(negedge clk);
    check("b2b_final_idle", done, 0);

    // Random operands with inputs scrambled during BUSY.
    for (int n = 0; n < 20; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult8.md
SEQ_MULT8 -- requirements
Module: seq_mult8

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width 16 bits.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, asynchronous, active-high; one clock only.
REQ-004 start  input  1  request a multiply; sampled on rising clk.
REQ-005 a  input  8  multiplicand, unsigned; sampled when start is accepted.
REQ-006 b  input  8  multiplier, unsigned; sampled when start is accepted.
REQ-007 busy  output  1  high while an operation is in progress (state BUSY).
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  16  registered unsigned result a*b; held until next done.

Function
REQ-010 The block SHALL be a shift-and-add multiplier that feeds the 8-bit ripple adder and consumes its sum and carry-out every BUSY cycle.
REQ-011 The FSM SHALL have states IDLE, BUSY and DONE only.
REQ-012 start SHALL be accepted in IDLE or DONE; start in BUSY SHALL be ignored with no side effect.
REQ-013 On acceptance (edge E0): M<=a, A<=0, Q<=b, count<=0, state<=BUSY.
REQ-014 Each BUSY cycle: adder X=A, Y=(Q[0] ? M : 8'h00), C0=0; {A,Q}<= {C8,sum,Q[7:1]} (9-bit carry-sum shifted right by 1 into Q).
REQ-015 BUSY SHALL last exactly 8 cycles; on edge E8: product<={A,Q} (post-shift), state<=DONE.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE (E8 to E9); busy low in that cycle.
REQ-017 From DONE without start: state<=IDLE; with start: new operation per REQ-013 (back-to-back, no idle cycle).
REQ-018 product SHALL change only at the edge that asserts done (or reset).
REQ-019 Arithmetic: 255*255 = 16'hFE01; no overflow possible; the adder carry SHALL never be dropped.
REQ-020 Operands SHALL be captured; a and b changing during BUSY SHALL not affect the result.

Reset
REQ-021 rst high SHALL immediately force state IDLE, busy=0, done=0, product=16'h0000, A=Q=M=0, count=0.
REQ-022 rst during BUSY SHALL abort the operation; no done pulse for it; product stays 0.
REQ-023 start coincident with rst high SHALL be ignored.

Configuration
REQ-024 Macro SEQ_MULT8_ZERO_BYPASS_EN, when defined: accepted start with a==0 or b==0 SHALL go directly to DONE at E0 with product<=0; done high E0 to E1; busy stays low.
REQ-025 Without SEQ_MULT8_ZERO_BYPASS_EN: zero operands SHALL take the full 8-cycle path and yield product 0 at E8.

Structure
REQ-026 Shared package seq_mult8_pkg SHALL hold state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the iteration count constant (8).
REQ-027 The design SHALL instantiate one sub-module: the existing 8-bit ripple adder adder8bit (ports X, Y, C0, sum, C8); the adder SHALL not be reimplemented inline.
REQ-028 Datapath registers (A, Q, M, 4-bit count) and FSM SHALL reside in seq_mult8; no combinational path from a/b to product.

Verification
REQ-029 a=13, b=11, start 1 cycle -> busy 8 cycles, done at E8, product=16'd143.
REQ-030 a=255, b=255 -> product=16'hFE01 at E8; a=128, b=2 -> 16'h0100.
REQ-031 a=0, b=77: macro defined -> done at E0, product=0, busy never high; undefined -> done at E8, product=0.
REQ-032 start with a=5, b=6, then start at E3 with a=9, b=9 -> second ignored; product=16'd30 at E8.
REQ-033 start a=200, b=3, rst pulse at E4 -> all outputs 0 immediately, no done; next start a=7, b=7 -> product=16'd49.
REQ-034 start held high continuously with a=3, b=4 -> done every 9 cycles, product=16'd12, no IDLE cycle between operations.
